// File: rtl/hyper_xfer_seq.sv
// hyper_xfer_seq -- queues HyperBus transfer descriptors and replays the cfg-register
// launch sequence for each one, waiting for the matching EOT event (rev 1.0)
`default_nettype none

module hyper_xfer_seq #(
  parameter int          DEPTH        = 4,
  parameter int          L2_AWIDTH    = 19,
  parameter int          TRANS_SIZE   = 20,
  parameter int          TIMEOUT_W    = 16,
  parameter logic [5:0]  REG_EXT_ADDR = 6'h00,
  parameter logic [5:0]  REG_L2_ADDR  = 6'h04,
  parameter logic [5:0]  REG_SIZE     = 6'h08,
  parameter logic [5:0]  REG_TRIG     = 6'h0C
) (
  input  logic                          sys_clk_i,
  input  logic                          rstn_i,
  input  logic                          desc_valid_i,
  output logic                          desc_ready_o,
  input  logic                          desc_rw_i,
  input  logic [L2_AWIDTH-1:0]          desc_l2_addr_i,
  input  logic [31:0]                   desc_ext_addr_i,
  input  logic [TRANS_SIZE-1:0]         desc_size_i,
  output logic                          cfg_valid_o,
  output logic                          cfg_rwn_o,
  output logic [5:0]                    cfg_addr_o,
  output logic [31:0]                   cfg_data_o,
  input  logic                          cfg_ready_i,
  input  logic [3:0]                    evt_i,
  output logic                          busy_o,
  output logic [$clog2(DEPTH+1)-1:0]    pending_o,
  output logic                          done_o,
  output logic                          err_o
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);
  localparam logic [TIMEOUT_W-1:0] CNT_ALL  = '1;
  // Erroring in the cycle whose increment would reach all-ones gives a window
  // of exactly 2^TIMEOUT_W-1 waiting cycles.
  localparam logic [TIMEOUT_W-1:0] CNT_LAST = CNT_ALL - TIMEOUT_W'(1);

  typedef struct packed {
    logic                  rw;
    logic [L2_AWIDTH-1:0]  l2;
    logic [31:0]           ext;
    logic [TRANS_SIZE-1:0] size;
  } desc_t;

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_W_EXT    = 3'd1,
    S_W_L2     = 3'd2,
    S_W_SIZE   = 3'd3,
    S_W_TRIG   = 3'd4,
    S_WAIT_EOT = 3'd5,
    S_DONE     = 3'd6
  } state_e;

  state_e                 state_q, state_d;
  desc_t                  mem_q [DEPTH];
  desc_t                  mem_d [DEPTH];
  logic [PW-1:0]          wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]          rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]          count_q, count_d;
  logic                   ready_q, ready_d;
  desc_t                  work_q, work_d;
  logic [TIMEOUT_W-1:0]   cnt_q, cnt_d;
  logic                   push_w;
  logic                   pop_w;
  logic                   match_w;
  logic                   evt_unused_w;

  assign evt_unused_w = ^evt_i[1:0];

  assign push_w  = desc_valid_i & ready_q;
  assign pop_w   = (state_q == S_IDLE) && (count_q != '0);
  assign match_w = work_q.rw ? evt_i[2] : evt_i[3];

  assign desc_ready_o = ready_q;
  assign pending_o    = count_q;
  assign busy_o       = (state_q != S_IDLE);
  assign cfg_rwn_o    = 1'b0;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_w) begin
      mem_d[wr_ptr_q] = '{rw: desc_rw_i, l2: desc_l2_addr_i,
                          ext: desc_ext_addr_i, size: desc_size_i};
      wr_ptr_d = wr_ptr_q + PW'(1);
    end
    if (pop_w) begin
      rd_ptr_d = rd_ptr_q + PW'(1);
    end
    case ({push_w, pop_w})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
    ready_d = (count_d != CW'(DEPTH));
  end

  always_comb begin
    state_d     = state_q;
    work_d      = work_q;
    cnt_d       = cnt_q;
    cfg_valid_o = 1'b0;
    cfg_addr_o  = 6'h00;
    cfg_data_o  = 32'h0;
    done_o      = 1'b0;
    err_o       = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (pop_w) begin
          work_d  = mem_q[rd_ptr_q];
          state_d = S_W_EXT;
        end
      end
      S_W_EXT: begin
        cfg_valid_o = 1'b1;
        cfg_addr_o  = REG_EXT_ADDR;
        cfg_data_o  = work_q.ext;
        if (cfg_ready_i) state_d = S_W_L2;
      end
      S_W_L2: begin
        cfg_valid_o = 1'b1;
        cfg_addr_o  = REG_L2_ADDR;
        cfg_data_o  = 32'(work_q.l2);
        if (cfg_ready_i) state_d = S_W_SIZE;
      end
      S_W_SIZE: begin
        cfg_valid_o = 1'b1;
        cfg_addr_o  = REG_SIZE;
        cfg_data_o  = 32'(work_q.size);
        if (cfg_ready_i) state_d = S_W_TRIG;
      end
      S_W_TRIG: begin
        cfg_valid_o = 1'b1;
        cfg_addr_o  = REG_TRIG;
        cfg_data_o  = {30'b0, work_q.rw, 1'b1};
        if (cfg_ready_i) begin
          state_d = S_WAIT_EOT;
          cnt_d   = '0;
        end
      end
      S_WAIT_EOT: begin
        // A match in the final waiting cycle still counts as completion.
        if (match_w) begin
          state_d = S_DONE;
        end else if (cnt_q == CNT_LAST) begin
          err_o   = 1'b1;
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q + TIMEOUT_W'(1);
        end
      end
      S_DONE: begin
        done_o  = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge sys_clk_i) begin
    if (!rstn_i) begin
      state_q  <= S_IDLE;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ready_q  <= 1'b1;
      work_q   <= '0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      ready_q  <= ready_d;
      work_q   <= work_d;
      cnt_q    <= cnt_d;
    end
  end

  // Storage needs no reset: the occupancy count alone decides what is valid.
  always_ff @(posedge sys_clk_i) begin
    mem_q <= mem_d;
  end

endmodule

`default_nettype wire

// File: tb/tb_hyper_xfer_seq.sv
// tb_hyper_xfer_seq -- scoreboard bench for hyper_xfer_seq: expected cfg writes and
// completion events are queued at issue time and popped by an independent monitor.
`default_nettype none

module tb_hyper_xfer_seq;

  localparam int DEPTH = 4;
  localparam int L2W   = 19;
  localparam int TS    = 20;
  localparam int TW    = 4;

  logic            clk = 1'b0;
  logic            rstn = 1'b0;
  logic            desc_valid_i = 1'b0;
  logic            desc_ready_o;
  logic            desc_rw_i = 1'b0;
  logic [L2W-1:0]  desc_l2_addr_i = '0;
  logic [31:0]     desc_ext_addr_i = '0;
  logic [TS-1:0]   desc_size_i = '0;
  logic            cfg_valid_o;
  logic            cfg_rwn_o;
  logic [5:0]      cfg_addr_o;
  logic [31:0]     cfg_data_o;
  logic            cfg_ready_i;
  logic [3:0]      evt_i = 4'h0;
  logic            busy_o;
  logic [2:0]      pending_o;
  logic            done_o;
  logic            err_o;

  logic rdy_set = 1'b1;
  logic rnd_en  = 1'b0;
  logic rnd_bit = 1'b0;
  assign cfg_ready_i = rnd_en ? rnd_bit : rdy_set;

  always #5 clk = ~clk;

  hyper_xfer_seq #(
    .DEPTH(DEPTH), .L2_AWIDTH(L2W), .TRANS_SIZE(TS), .TIMEOUT_W(TW)
  ) dut (
    .sys_clk_i(clk), .rstn_i(rstn),
    .desc_valid_i(desc_valid_i), .desc_ready_o(desc_ready_o),
    .desc_rw_i(desc_rw_i), .desc_l2_addr_i(desc_l2_addr_i),
    .desc_ext_addr_i(desc_ext_addr_i), .desc_size_i(desc_size_i),
    .cfg_valid_o(cfg_valid_o), .cfg_rwn_o(cfg_rwn_o), .cfg_addr_o(cfg_addr_o),
    .cfg_data_o(cfg_data_o), .cfg_ready_i(cfg_ready_i), .evt_i(evt_i),
    .busy_o(busy_o), .pending_o(pending_o), .done_o(done_o), .err_o(err_o)
  );

  typedef struct packed {
    logic [5:0]  a;
    logic [31:0] d;
  } wr_t;

  wr_t wq[$];
  int  eq[$];          // 0 = done expected, 1 = err expected
  int  n_chk  = 0;
  int  n_fail = 0;
  int  n_trig = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(posedge clk) begin
    #1 rnd_bit = 1'($urandom_range(0, 1));
  end

  // Monitor: compares every accepted cfg write and every done/err pulse.
  logic        pv = 1'b0, pr = 1'b0;
  logic [5:0]  pa = '0;
  logic [31:0] pd = '0;
  always @(negedge clk) begin
    wr_t w;
    int  e;
    if (rstn) begin
      if (cfg_valid_o && pv && !pr)
        check("cfg_stable", {cfg_addr_o, cfg_data_o}, {pa, pd});
      if (cfg_valid_o && cfg_ready_i) begin
        if (wq.size() == 0) begin
          n_chk++; n_fail++;
          $display("FAIL unexpected_cfg_write: got addr 0x%0h data 0x%0h expected none", cfg_addr_o, cfg_data_o);
        end else begin
          w = wq.pop_front();
          check("cfg_write", {cfg_rwn_o, cfg_addr_o, cfg_data_o}, {1'b0, w.a, w.d});
          if (w.a == 6'h0C) n_trig++;
        end
      end
      if (done_o || err_o) begin
        if (eq.size() == 0) begin
          n_chk++; n_fail++;
          $display("FAIL unexpected_eot: got done=%0b err=%0b expected none", done_o, err_o);
        end else begin
          e = eq.pop_front();
          check("eot_result", {62'b0, done_o, err_o}, (e == 1) ? 64'h1 : 64'h2);
        end
      end
    end
    pv = cfg_valid_o & rstn;
    pr = cfg_ready_i;
    pa = cfg_addr_o;
    pd = cfg_data_o;
  end

  // Drive one descriptor starting now (just after an edge); returns just after its accepting edge.
  task automatic push(input logic rw, input logic [L2W-1:0] l2, input logic [31:0] ext, input logic [TS-1:0] sz);
    bit acc = 0;
    wq.push_back('{a: 6'h00, d: ext});
    wq.push_back('{a: 6'h04, d: 32'(l2)});
    wq.push_back('{a: 6'h08, d: 32'(sz)});
    wq.push_back('{a: 6'h0C, d: {30'b0, rw, 1'b1}});
    desc_rw_i = rw; desc_l2_addr_i = l2; desc_ext_addr_i = ext; desc_size_i = sz;
    desc_valid_i = 1'b1;
    for (int i = 0; i < 200 && !acc; i++) begin
      @(negedge clk);
      acc = desc_ready_o;
      @(posedge clk);
    end
    #1 desc_valid_i = 1'b0;
    if (!acc) begin
      n_chk++; n_fail++;
      $display("FAIL push_timeout: got ready=0 expected ready=1 within 200 cycles");
    end
  endtask

  // Returns just after the edge that accepted trigger write number 'target'.
  task automatic wait_trig(input int target);
    bit ok = 0;
    for (int i = 0; i < 300 && !ok; i++) begin
      @(negedge clk); #1;
      ok = (n_trig >= target);
    end
    @(posedge clk); #1;
    if (!ok) begin
      n_chk++; n_fail++;
      $display("FAIL trig_timeout: got %0d triggers expected %0d", n_trig, target);
    end
  endtask

  task automatic pulse_evt(input int b);
    evt_i = 4'(1 << b);
    @(posedge clk); #1;
    evt_i = 4'h0;
  endtask

  task automatic wait_drain();
    bit ok = 0;
    for (int i = 0; i < 300 && !ok; i++) begin
      @(negedge clk); #1;
      ok = (wq.size() == 0) && (eq.size() == 0) && !busy_o;
    end
    @(posedge clk); #1;
    if (!ok) begin
      n_chk++; n_fail++;
      $display("FAIL drain_timeout: got %0d writes %0d events outstanding expected 0", wq.size(), eq.size());
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no end of test expected finish before 200000");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_outputs",
          {desc_ready_o, pending_o, cfg_valid_o, cfg_rwn_o, cfg_addr_o, cfg_data_o, busy_o, done_o, err_o},
          {1'b1, 3'd0, 1'b0, 1'b0, 6'h00, 32'h0, 1'b0, 1'b0, 1'b0});
    @(posedge clk); #1 rstn = 1'b1;

    // Single read transfer, exact write timing
    push(1'b1, 19'h100, 32'h2000, 20'd64);
    eq.push_back(0);
    @(negedge clk);
    check("first_write_not_yet", {cfg_valid_o, pending_o}, {1'b0, 3'd1});
    @(negedge clk);
    check("w_ext_cycle", {cfg_valid_o, cfg_addr_o, cfg_data_o}, {1'b1, 6'h00, 32'h2000});
    @(negedge clk);
    check("w_l2_cycle", {cfg_valid_o, cfg_addr_o, cfg_data_o}, {1'b1, 6'h04, 32'h100});
    @(negedge clk);
    check("w_size_cycle", {cfg_valid_o, cfg_addr_o, cfg_data_o}, {1'b1, 6'h08, 32'd64});
    @(negedge clk);
    check("w_trig_cycle", {cfg_valid_o, cfg_addr_o, cfg_data_o}, {1'b1, 6'h0C, 32'h3});
    @(posedge clk); #1;
    check("wait_eot_idle_cfg", {cfg_valid_o, busy_o}, {1'b0, 1'b1});
    pulse_evt(2);
    @(negedge clk);
    check("done_after_evt", {done_o, busy_o}, {1'b1, 1'b1});
    @(negedge clk);
    check("idle_after_done", {done_o, busy_o}, {1'b0, 1'b0});
    wait_drain();

    // Write transfer ignores read EOT; size 0 sequenced normally
    push(1'b0, 19'h7F, 32'h1234_5678, 20'd0);
    eq.push_back(0);
    wait_trig(2);
    pulse_evt(2);
    @(negedge clk);
    check("wrong_evt_ignored", {busy_o, done_o}, {1'b1, 1'b0});
    @(posedge clk); #1;
    pulse_evt(3);
    wait_drain();

    // Five descriptors with the cfg port stalled, then random cfg_ready
    rdy_set = 1'b0;
    for (int i = 0; i < 5; i++) begin
      push(1'(i % 2), L2W'(19'h200 + i), 32'h4000_0000 + 32'(i * 16), TS'(8 * (i + 1)));
      eq.push_back(0);
    end
    @(negedge clk);
    check("fifo_full", {desc_ready_o, pending_o}, {1'b0, 3'd4});
    @(posedge clk); #1;
    rnd_en = 1'b1;
    for (int k = 0; k < 5; k++) begin
      wait_trig(3 + k);
      pulse_evt((k % 2 == 1) ? 2 : 3);
    end
    wait_drain();
    rnd_en = 1'b0;
    rdy_set = 1'b1;

    // EOT timeout, then the queued descriptor proceeds
    push(1'b1, 19'h3, 32'hAAAA, 20'd16);
    eq.push_back(1);
    push(1'b0, 19'h5, 32'hBBBB, 20'd32);
    eq.push_back(0);
    wait_trig(8);
    for (int k = 1; k <= 15; k++) begin
      @(negedge clk);
      check("timeout_window", {62'b0, done_o, err_o}, (k == 15) ? 64'h1 : 64'h0);
    end
    wait_trig(9);
    pulse_evt(3);
    wait_drain();

    // Reset in W_SIZE with two descriptors pending
    rdy_set = 1'b0;
    for (int i = 0; i < 3; i++) push(1'b1, L2W'(i), 32'hC000 + 32'(i), TS'(4));
    rdy_set = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rdy_set = 1'b0;
    @(negedge clk);
    check("in_w_size", {cfg_valid_o, cfg_addr_o, pending_o}, {1'b1, 6'h08, 3'd2});
    @(posedge clk); #1 rstn = 1'b0;
    @(posedge clk); #1;
    wq.delete();
    eq.delete();
    @(negedge clk);
    check("mid_op_reset",
          {desc_ready_o, pending_o, cfg_valid_o, cfg_rwn_o, cfg_addr_o, cfg_data_o, busy_o, done_o, err_o},
          {1'b1, 3'd0, 1'b0, 1'b0, 6'h00, 32'h0, 1'b0, 1'b0, 1'b0});
    @(posedge clk); #1 rstn = 1'b1;
    rdy_set = 1'b1;
    repeat (10) @(posedge clk);
    @(negedge clk);
    check("no_work_after_reset", {busy_o, pending_o, cfg_valid_o}, {1'b0, 3'd0, 1'b0});
    check("queues_drained", 64'(wq.size() + eq.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/hyper_xfer_seq.md
Name: hyper_xfer_seq

Overview:
- Transfer sequencer directly upstream of the hyper macro's configuration port.
- Accepts HyperBus transfer descriptors into a small FIFO.
- For each descriptor, issues the fixed cfg-register write sequence that launches the transfer, then waits for the macro's read-EOT or write-EOT event before starting the next one.
- Lets software or a controller queue several hyperram transfers without polling.

Parameters:
- DEPTH, 4, descriptor FIFO depth (power of two, >=2).
- L2_AWIDTH, 19, L2 address width (matches L2_AWIDTH_NOAL).
- TRANS_SIZE, 20, transfer size width in bytes.
- TIMEOUT_W, 16, EOT timeout counter width; timeout = 2^TIMEOUT_W-1 cycles.
- REG_EXT_ADDR, 6'h00, cfg offset of the external (hyperram) address register.
- REG_L2_ADDR, 6'h04, cfg offset of the L2 start-address register.
- REG_SIZE, 6'h08, cfg offset of the transfer-size register.
- REG_TRIG, 6'h0C, cfg offset of the transfer trigger register.

Ports:
- sys_clk_i  in  1  system clock
- rstn_i  in  1  synchronous active-low reset
- desc_valid_i  in  1  descriptor valid
- desc_ready_o  out  1  descriptor ready (FIFO not full)
- desc_rw_i  in  1  1 = read (hyperram->L2), 0 = write
- desc_l2_addr_i  in  L2_AWIDTH  L2 start address
- desc_ext_addr_i  in  32  hyperram byte address
- desc_size_i  in  TRANS_SIZE  byte count
- cfg_valid_o  out  1  cfg write request
- cfg_rwn_o  out  1  always 0 (write)
- cfg_addr_o  out  6  cfg register offset
- cfg_data_o  out  32  cfg write data
- cfg_ready_i  in  1  cfg accept
- evt_i  in  4  macro events; [2] = read EOT, [3] = write EOT; [1:0] ignored
- busy_o  out  1  FSM not IDLE
- pending_o  out  $clog2(DEPTH+1)  FIFO occupancy
- done_o  out  1  one-cycle pulse: transfer completed
- err_o  out  1  one-cycle pulse: EOT timeout

Behaviour:
- Clock and reset: one clock, sys_clk_i. Reset is synchronous and active-low on rstn_i.
- Reset values:
  - desc_ready_o=1, pending_o=0, cfg_valid_o=0, cfg_rwn_o=0, cfg_addr_o=0, cfg_data_o=0.
  - busy_o=0, done_o=0, err_o=0. FSM in IDLE, FIFO empty, timeout counter 0.
  - Reset mid-operation aborts all state and discards queued descriptors; no done/err pulse is emitted.
- FIFO:
  - Push on desc_valid_i & desc_ready_o. desc_ready_o = !full, registered from occupancy.
  - No push when full, even if a pop occurs in the same cycle.
  - Simultaneous push and pop leaves pending_o unchanged.
  - Pointers wrap modulo DEPTH.
- FSM states: IDLE, W_EXT, W_L2, W_SIZE, W_TRIG, WAIT_EOT, DONE.
- IDLE: if the FIFO is not empty, pop the head into the working registers and go to W_EXT. A descriptor pushed into an empty FIFO at edge N gives cfg_valid_o=1 from the cycle after edge N+1.
- Write states:
  - cfg_valid_o=1 with a stable addr/data until cfg_ready_i=1; advance on the accepting edge.
  - cfg_valid_o may stay high across back-to-back writes; there is no idle cycle between writes.
  - W_EXT: addr REG_EXT_ADDR, data ext_addr.
  - W_L2: addr REG_L2_ADDR, data zero-extended l2_addr.
  - W_SIZE: addr REG_SIZE, data zero-extended size.
  - W_TRIG: addr REG_TRIG, data {30'b0, rw, 1'b1}. Then go to WAIT_EOT and clear the timeout counter.
- WAIT_EOT:
  - cfg_valid_o=0.
  - Match event = evt_i[2] if rw=1, else evt_i[3]. On a match, go to DONE.
  - Non-matching events are ignored. Events arriving outside WAIT_EOT are ignored and not latched.
  - Otherwise the counter increments. At all-ones, pulse err_o for one cycle and return to IDLE without done_o.
  - Match and counter at all-ones in the same cycle: the match wins.
- DONE: done_o=1 for exactly one cycle, then IDLE. The next descriptor's pop occurs in the following IDLE cycle.
- busy_o=1 in every state except IDLE.
- size=0 is sequenced normally; no special case.

Test Plan:
- Reset, then push one read descriptor {rw=1, l2=0x100, ext=0x2000, size=64}, cfg_ready_i=1:
  - cfg writes (00,0x2000), (04,0x100), (08,64), (0C,0x3) on consecutive cycles; first write 2 cycles after accept.
  - Pulse evt_i[2] -> done_o one cycle later.
- Write descriptor (rw=0) while pulsing evt_i[2] -> no completion and the FSM stays in WAIT_EOT; evt_i[3] -> done_o.
- Push 5 descriptors back-to-back with DEPTH=4 and the FSM stalled (cfg_ready_i=0):
  - desc_ready_o drops after 4 are held in the FIFO; pending_o=4.
  - Release cfg_ready_i and complete all transfers -> 5 done_o pulses in FIFO order.
- cfg_ready_i toggled randomly -> each write's addr/data stable while valid; exactly 4 accepted writes per descriptor.
- TIMEOUT_W=4, no EOT -> err_o at the 15th WAIT_EOT cycle, no done_o, next descriptor starts.
- Assert rstn_i=0 during W_SIZE with 2 pending -> all outputs at reset values next cycle, pending_o=0.
